alarm_clk_ctrl: RTL and testbench
=================================

# alarm_clk_ctrl

User-interface controller for `alarm_clk`. It debounces three push-buttons and walks an edit state machine through time-set and alarm-set fields. It drives the `LoadTime`/`LoadAlm` sequencing and the set-value buses into `alarm_clk`, and gates the raw `Alarm` output into a buzzer with snooze and auto-silence. It runs on the 1 ms tick from `clock_gen` and sits between the board buttons and `alarm_clk`.

## Interface
Parameters:
- `DEBOUNCE_MS`, 20, cycles a raw button level must be stable before it is accepted
- `LOAD_HOLD_MS`, 1100, cycles `LoadTime`/`LoadAlm` are held high; must exceed one `Clock_1Sec` period
- `EDIT_TIMEOUT_MS`, 10000, idle cycles in an edit state before abandoning the edit
- `SNOOZE_MS`, 300000, buzzer suppression after a snooze press
- `ALARM_TIMEOUT_MS`, 60000, continuous buzzing before auto-silence

Ports:
- `Clock_1MSec` in 1: the single clock, 1 kHz
- `Reset` in 1: asynchronous, active-high
- `ModeBtn`, `IncBtn`, `SnoozeBtn` in 1 each: raw, asynchronous, active-high
- `Alarm` in 1: from `alarm_clk`
- `Hours_C` in 4, `Mins_C` in 6, `AM_PM` in 1: current time from `alarm_clk`
- `LoadTime`, `LoadAlm` out 1: load strobes to `alarm_clk`
- `SetHours` out 4, `SetMins` out 6, `SetSecs` out 6, `Set_AM_PM` out 1: time shadow
- `AlarmHoursIn` out 4, `AlarmMinsIn` out 6, `Alarm_AM_PM_In` out 1: alarm shadow
- `AlarmEnable` out 1: alarm arm
- `Buzzer` out 1: gated alarm
- `EditState` out 4: current FSM state, for the display

## Operation
- **Buttons.** Each button goes through a 2-FF synchronizer, then a stability counter. The debounced level changes only after `DEBOUNCE_MS` consecutive equal samples. A press is a 1-cycle pulse on the debounced rising edge.
- **FSM states:** RUN=0, T_HR=1, T_MIN=2, T_AMPM=3, T_LOAD=4, A_HR=5, A_MIN=6, A_AMPM=7, A_LOAD=8.
- **Mode press transitions:**
  - RUN→T_HR. On entry, the time shadow is copied from `Hours_C`/`Mins_C`/`AM_PM`.
  - T_HR→T_MIN→T_AMPM→T_LOAD.
  - A_HR→A_MIN→A_AMPM→A_LOAD.
- **Load states.**
  - T_LOAD holds `LoadTime`=1 for exactly `LOAD_HOLD_MS` cycles, with `SetSecs`=0, then goes to A_HR.
  - A_LOAD holds `LoadAlm`=1 for `LOAD_HOLD_MS` cycles, then goes to RUN.
  - All presses are ignored in load states.
- **Inc press.**
  - In T_HR/A_HR: hours 1..12, 12 wraps to 1.
  - In T_MIN/A_MIN: minutes 0..59, 59 wraps to 0.
  - In T_AMPM/A_AMPM: toggles AM/PM.
  - In RUN: toggles `AlarmEnable`.
- **Simultaneous Mode and Inc press:** Mode wins and Inc is dropped.
- **Edit timeout.** In states 1–3 and 5–7, `EDIT_TIMEOUT_MS` cycles with no Mode or Inc press returns the FSM to RUN with no load. The shadows keep their edited values. The idle counter restarts on every Mode or Inc press.
- **Shadow stability.** Shadows change only on Inc presses or on T_HR entry. They are stable throughout load states.
- **Buzzer.**
  - `Buzzer` = `Alarm` & `AlarmEnable` & ~snoozing & ~silenced.
  - A Snooze press while `Buzzer`=1 sets snoozing for `SNOOZE_MS` cycles. A Snooze press while snoozing restarts the count.
  - A `Buzzer` high for `ALARM_TIMEOUT_MS` consecutive cycles sets silenced.
  - Silenced clears on a falling edge of `Alarm`, or when `AlarmEnable` goes to 0. That same `AlarmEnable`=0 also clears snoozing.

## Timing
- **Reset values:**
  - FSM in RUN.
  - `LoadTime`=`LoadAlm`=0.
  - Time shadow = alarm shadow = 12:00 AM (hours=12, mins=0, AM_PM=0); `SetSecs`=0.
  - `AlarmEnable`=0, `Buzzer`=0, all counters 0.
- **Press latency:** a raw level reaches its press pulse in 2 + `DEBOUNCE_MS` cycles. The state and shadow update in the cycle after the pulse.
- **Load strobes:**
  - `LoadTime` rises in the first cycle of T_LOAD and falls when the FSM enters A_HR.
  - `LoadTime` and `LoadAlm` are never high together.
- **Reset mid-load:** both strobes drop immediately (asynchronous). No partial state survives.
- **`Buzzer`** is registered: one cycle after `Alarm` or the gating changes.
- **Hold-time rule:** the set buses are valid from the cycle before the strobe rises until it falls.

## Structure
- **Package `alarm_ctrl_pkg`:**
  - state encoding localparams
  - `HOUR_MIN`=1, `HOUR_MAX`=12, `MIN_MAX`=59
  - the field widths (4/6/1)
- **Sub-module `btn_debounce`** (synchronizer + stability counter + press pulse), parameterized by `DEBOUNCE_MS` and instantiated three times.
- **Top level:** FSM, shadows, edit/load/snooze/timeout counters. The 19-bit snooze counter is the widest.

## Test plan
Run the bench with reduced parameters: DEBOUNCE_MS=4, LOAD_HOLD_MS=10, EDIT_TIMEOUT_MS=50, SNOOZE_MS=40, ALARM_TIMEOUT_MS=30.
- **Bounce:** `ModeBtn` toggling every 2 cycles for 20 cycles, then held high → exactly one RUN→T_HR transition, 6 cycles after the last edge.
- **Time-set wrap:** current time 11:59 PM, enter edit, Inc×1 in T_HR, Inc×1 in T_MIN, Inc×1 in T_AMPM, Mode → `LoadTime` high for exactly 10 cycles with `SetHours`=12, `SetMins`=0, `Set_AM_PM`=0, `SetSecs`=0; then FSM=A_HR.
- **Alarm set:** A_HR Inc×6 from 12 → 6; A_MIN Inc×30 → 30; A_AMPM Inc → PM; Mode → `LoadAlm` for 10 cycles, then RUN; `LoadTime` stays 0.
- **Edit timeout:** enter T_MIN, no presses for 50 cycles → RUN, no strobe.
- **Snooze and auto-silence:** `AlarmEnable`=1, `Alarm`=1.
  - Snooze press → `Buzzer`=0 for 40 cycles, then `Buzzer`=1.
  - After 30 more cycles → `Buzzer`=0 until `Alarm` falls.
- **Simultaneous Mode+Inc in T_HR:** → FSM=T_MIN, hours unchanged. Reset asserted mid-T_LOAD → `LoadTime`=0 at once, FSM=RUN, shadows = 12:00 AM.

Source files
------------

// File: rtl/alarm_ctrl_pkg.sv
// Shared encodings, field widths and wrap helpers for the alarm clock UI controller.
package alarm_ctrl_pkg;

  localparam int HR_W  = 4;
  localparam int MIN_W = 6;
  localparam int AP_W  = 1;
  localparam int SEC_W = 6;
  localparam int ST_W  = 4;

  localparam logic [HR_W-1:0]  HOUR_MIN = 4'd1;
  localparam logic [HR_W-1:0]  HOUR_MAX = 4'd12;
  localparam logic [MIN_W-1:0] MIN_MAX  = 6'd59;

  typedef enum logic [ST_W-1:0] {
    ST_RUN    = 4'd0,
    ST_T_HR   = 4'd1,
    ST_T_MIN  = 4'd2,
    ST_T_AMPM = 4'd3,
    ST_T_LOAD = 4'd4,
    ST_A_HR   = 4'd5,
    ST_A_MIN  = 4'd6,
    ST_A_AMPM = 4'd7,
    ST_A_LOAD = 4'd8
  } edit_state_e;

  // 12-hour dial: 12 rolls over to 1; anything out of range also lands on 1.
  function automatic logic [HR_W-1:0] next_hour(input logic [HR_W-1:0] h);
    return (h >= HOUR_MAX) ? HOUR_MIN : h + HR_W'(1);
  endfunction

  // Minutes roll 59 -> 0.
  function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] m);
    return (m >= MIN_MAX) ? '0 : m + MIN_W'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, 1-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  // Counter only needs to reach DEBOUNCE_MS-1; the D-th differing sample flips the level.
  localparam int CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level after DEBOUNCE_MS consecutive differing samples; pulse on accepted rise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_MS - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alarm_clk_ctrl.sv
// Button-driven edit FSM, time/alarm shadows, load strobes and buzzer gating for alarm_clk.
module alarm_clk_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_MS      = 20,
  parameter int LOAD_HOLD_MS     = 1100,
  parameter int EDIT_TIMEOUT_MS  = 10000,
  parameter int SNOOZE_MS        = 300000,
  parameter int ALARM_TIMEOUT_MS = 60000
) (
  input  logic             Clock_1MSec,
  input  logic             Reset,
  input  logic             ModeBtn,
  input  logic             IncBtn,
  input  logic             SnoozeBtn,
  input  logic             Alarm,
  input  logic [HR_W-1:0]  Hours_C,
  input  logic [MIN_W-1:0] Mins_C,
  input  logic             AM_PM,
  output logic             LoadTime,
  output logic             LoadAlm,
  output logic [HR_W-1:0]  SetHours,
  output logic [MIN_W-1:0] SetMins,
  output logic [SEC_W-1:0] SetSecs,
  output logic             Set_AM_PM,
  output logic [HR_W-1:0]  AlarmHoursIn,
  output logic [MIN_W-1:0] AlarmMinsIn,
  output logic             Alarm_AM_PM_In,
  output logic             AlarmEnable,
  output logic             Buzzer,
  output logic [ST_W-1:0]  EditState
);

  localparam int IDLE_W = $clog2(EDIT_TIMEOUT_MS + 1);
  localparam int LOAD_W = $clog2(LOAD_HOLD_MS + 1);
  localparam int SNZ_W  = (SNOOZE_MS > 1) ? $clog2(SNOOZE_MS) : 1;
  localparam int BUZ_W  = $clog2(ALARM_TIMEOUT_MS + 1);

  logic mode_p, inc_p, snz_p;

  edit_state_e       state_q;
  logic              load_time_q, load_alm_q;
  logic [IDLE_W-1:0] idle_q;
  logic [LOAD_W-1:0] load_q;
  logic [HR_W-1:0]   t_hr_q, a_hr_q;
  logic [MIN_W-1:0]  t_min_q, a_min_q;
  logic              t_ap_q, a_ap_q;
  logic              en_q;

  logic              buzzer_q, buzzer_d;
  logic              alarm_q;
  logic              silenced_q;
  logic [SNZ_W-1:0]  snz_q;
  logic [BUZ_W-1:0]  buz_q;
  logic              snz_hit, snoozing, alarm_fall;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_mode (
    .clk_i(Clock_1MSec), .rst_i(Reset), .btn_i(ModeBtn), .press_o(mode_p));
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_inc (
    .clk_i(Clock_1MSec), .rst_i(Reset), .btn_i(IncBtn), .press_o(inc_p));
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_snz (
    .clk_i(Clock_1MSec), .rst_i(Reset), .btn_i(SnoozeBtn), .press_o(snz_p));

  // Edit FSM: Mode walks fields, Inc edits the current field, idle edits time out, load states hold the strobe.
  always_ff @(posedge Clock_1MSec or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_RUN;
      load_time_q <= 1'b0;
      load_alm_q  <= 1'b0;
      idle_q      <= '0;
      load_q      <= '0;
      t_hr_q      <= HOUR_MAX;
      t_min_q     <= '0;
      t_ap_q      <= 1'b0;
      a_hr_q      <= HOUR_MAX;
      a_min_q     <= '0;
      a_ap_q      <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          idle_q <= '0;
          load_q <= '0;
          if (mode_p) begin
            state_q <= ST_T_HR;
            t_hr_q  <= Hours_C;
            t_min_q <= Mins_C;
            t_ap_q  <= AM_PM;
          end else if (inc_p) begin
            en_q <= ~en_q;
          end
        end

        ST_T_HR, ST_T_MIN, ST_T_AMPM, ST_A_HR, ST_A_MIN, ST_A_AMPM: begin
          if (mode_p) begin
            // Mode has priority; a coincident Inc is dropped.
            idle_q <= '0;
            load_q <= '0;
            case (state_q)
              ST_T_HR:   state_q <= ST_T_MIN;
              ST_T_MIN:  state_q <= ST_T_AMPM;
              ST_T_AMPM: begin state_q <= ST_T_LOAD; load_time_q <= 1'b1; end
              ST_A_HR:   state_q <= ST_A_MIN;
              ST_A_MIN:  state_q <= ST_A_AMPM;
              default:   begin state_q <= ST_A_LOAD; load_alm_q <= 1'b1; end
            endcase
          end else if (inc_p) begin
            idle_q <= '0;
            case (state_q)
              ST_T_HR:   t_hr_q  <= next_hour(t_hr_q);
              ST_T_MIN:  t_min_q <= next_min(t_min_q);
              ST_T_AMPM: t_ap_q  <= ~t_ap_q;
              ST_A_HR:   a_hr_q  <= next_hour(a_hr_q);
              ST_A_MIN:  a_min_q <= next_min(a_min_q);
              default:   a_ap_q  <= ~a_ap_q;
            endcase
          end else if (idle_q == IDLE_W'(EDIT_TIMEOUT_MS - 1)) begin
            // Abandon the edit; shadows keep whatever was entered.
            state_q <= ST_RUN;
            idle_q  <= '0;
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end

        ST_T_LOAD: begin
          if (load_q == LOAD_W'(LOAD_HOLD_MS - 1)) begin
            state_q     <= ST_A_HR;
            load_time_q <= 1'b0;
            load_q      <= '0;
            idle_q      <= '0;
          end else begin
            load_q <= load_q + LOAD_W'(1);
          end
        end

        ST_A_LOAD: begin
          if (load_q == LOAD_W'(LOAD_HOLD_MS - 1)) begin
            state_q    <= ST_RUN;
            load_alm_q <= 1'b0;
            load_q     <= '0;
          end else begin
            load_q <= load_q + LOAD_W'(1);
          end
        end

        default: begin
          state_q     <= ST_RUN;
          load_time_q <= 1'b0;
          load_alm_q  <= 1'b0;
          idle_q      <= '0;
          load_q      <= '0;
        end
      endcase
    end
  end

  // A snooze press counts only while buzzing or already snoozing; it gates the buzzer in the same cycle.
  assign snz_hit    = snz_p & (buzzer_q | (snz_q != '0));
  assign snoozing   = (snz_q != '0) | snz_hit;
  assign alarm_fall = alarm_q & ~Alarm;
  assign buzzer_d   = Alarm & en_q & ~snoozing & ~silenced_q;

  // Snooze countdown; loaded with SNOOZE_MS-1 so the press cycle itself is the first silent one.
  always_ff @(posedge Clock_1MSec or posedge Reset) begin
    if (Reset) begin
      snz_q <= '0;
    end else if (!en_q) begin
      snz_q <= '0;
    end else if (snz_hit) begin
      snz_q <= SNZ_W'(SNOOZE_MS - 1);
    end else if (snz_q != '0) begin
      snz_q <= snz_q - SNZ_W'(1);
    end
  end

  // Registered buzzer with auto-silence after ALARM_TIMEOUT_MS continuous buzzing cycles.
  always_ff @(posedge Clock_1MSec or posedge Reset) begin
    if (Reset) begin
      alarm_q    <= 1'b0;
      buzzer_q   <= 1'b0;
      silenced_q <= 1'b0;
      buz_q      <= '0;
    end else begin
      alarm_q <= Alarm;
      if (!en_q || alarm_fall) begin
        silenced_q <= 1'b0;
        buz_q      <= '0;
        buzzer_q   <= 1'b0;
      end else if (buzzer_d) begin
        if (buz_q == BUZ_W'(ALARM_TIMEOUT_MS)) begin
          silenced_q <= 1'b1;
          buz_q      <= '0;
          buzzer_q   <= 1'b0;
        end else begin
          buz_q    <= buz_q + BUZ_W'(1);
          buzzer_q <= 1'b1;
        end
      end else begin
        buz_q    <= '0;
        buzzer_q <= 1'b0;
      end
    end
  end

  assign LoadTime       = load_time_q;
  assign LoadAlm        = load_alm_q;
  assign SetHours       = t_hr_q;
  assign SetMins        = t_min_q;
  assign Set_AM_PM      = t_ap_q;
  assign SetSecs        = '0;
  assign AlarmHoursIn   = a_hr_q;
  assign AlarmMinsIn    = a_min_q;
  assign Alarm_AM_PM_In = a_ap_q;
  assign AlarmEnable    = en_q;
  assign Buzzer         = buzzer_q;
  assign EditState      = state_q;

endmodule

// File: tb/tb_alarm_clk_ctrl.sv
// Self-checking bench for alarm_clk_ctrl with shortened timing parameters.
module tb_alarm_clk_ctrl;

  localparam int DB = 4, LH = 10, ET = 50, SZ = 40, AT = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_b = 1'b0, inc_b = 1'b0, snz_b = 1'b0, alarm = 1'b0;
  logic [3:0] hc = 4'd1;
  logic [5:0] mc = 6'd0;
  logic       apc = 1'b0;
  logic       LoadTime, LoadAlm, Set_AM_PM, Alarm_AM_PM_In, AlarmEnable, Buzzer;
  logic [3:0] SetHours, AlarmHoursIn, EditState;
  logic [5:0] SetMins, SetSecs, AlarmMinsIn;

  int total = 0, bad = 0;
  // reference model: shadows as plain integers
  int m_th, m_tm, m_tap, m_ah, m_am, m_aap, m_en;

  alarm_clk_ctrl #(
    .DEBOUNCE_MS(DB), .LOAD_HOLD_MS(LH), .EDIT_TIMEOUT_MS(ET),
    .SNOOZE_MS(SZ), .ALARM_TIMEOUT_MS(AT)
  ) dut (
    .Clock_1MSec(clk), .Reset(rst), .ModeBtn(mode_b), .IncBtn(inc_b), .SnoozeBtn(snz_b),
    .Alarm(alarm), .Hours_C(hc), .Mins_C(mc), .AM_PM(apc),
    .LoadTime(LoadTime), .LoadAlm(LoadAlm), .SetHours(SetHours), .SetMins(SetMins),
    .SetSecs(SetSecs), .Set_AM_PM(Set_AM_PM), .AlarmHoursIn(AlarmHoursIn),
    .AlarmMinsIn(AlarmMinsIn), .Alarm_AM_PM_In(Alarm_AM_PM_In),
    .AlarmEnable(AlarmEnable), .Buzzer(Buzzer), .EditState(EditState)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold buttons well past debounce, then release long enough for the release to settle.
  task automatic press(input bit m, input bit i, input bit s);
    mode_b = m; inc_b = i; snz_b = s;
    tick(10);
    mode_b = 1'b0; inc_b = 1'b0; snz_b = 1'b0;
    tick(10);
  endtask

  function automatic int hr_inc(input int h);
    return (h % 12) + 1;
  endfunction

  task automatic model_reset();
    m_th = 12; m_tm = 0; m_tap = 0; m_ah = 12; m_am = 0; m_aap = 0; m_en = 0;
  endtask

  task automatic randomize_now();
    hc  = 4'($urandom_range(1, 12));
    mc  = 6'($urandom_range(0, 59));
    apc = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    logic [16:0] exp_t, act_t;
    rst = 1'b1;
    tick(3);
    model_reset();
    total++; if (EditState !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", EditState); end
    total++; if ({LoadTime, LoadAlm, AlarmEnable, Buzzer} !== 4'b0000) begin
      bad++; $display("FAIL reset_outs: got %b want 0000", {LoadTime, LoadAlm, AlarmEnable, Buzzer}); end
    exp_t = {4'd12, 6'd0, 1'b0, 6'd0};
    act_t = {SetHours, SetMins, Set_AM_PM, SetSecs};
    total++; if (act_t !== exp_t) begin bad++; $display("FAIL reset_time_shadow: got %h want %h", act_t, exp_t); end
    total++; if ({AlarmHoursIn, AlarmMinsIn, Alarm_AM_PM_In} !== {4'd12, 6'd0, 1'b0}) begin
      bad++; $display("FAIL reset_alarm_shadow: got %h want %h", {AlarmHoursIn, AlarmMinsIn, Alarm_AM_PM_In}, {4'd12, 6'd0, 1'b0}); end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_bounce();
    int changes = 0;
    logic [3:0] prev, st5, st8;
    logic [16:0] exp_t, act_t;
    randomize_now();
    prev = EditState; st5 = 4'hf; st8 = 4'hf;
    for (int i = 0; i < 10; i++) begin
      mode_b = ~mode_b;
      repeat (2) begin
        @(negedge clk);
        if (EditState !== prev) changes++;
        prev = EditState;
      end
    end
    mode_b = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 12) mode_b = 1'b0;
      if (EditState !== prev) changes++;
      prev = EditState;
      if (k == 5) st5 = EditState;
      if (k == 8) st8 = EditState;
    end
    m_th = hc; m_tm = mc; m_tap = apc;
    total++; if (changes != 1) begin bad++; $display("FAIL bounce_transitions: got %0d want 1", changes); end
    total++; if (st5 !== 4'd0) begin bad++; $display("FAIL bounce_early: got %0d want 0", st5); end
    total++; if (st8 !== 4'd1) begin bad++; $display("FAIL bounce_entry: got %0d want 1", st8); end
    exp_t = {4'(m_th), 6'(m_tm), 1'(m_tap), 6'd0};
    act_t = {SetHours, SetMins, Set_AM_PM, SetSecs};
    total++; if (act_t !== exp_t) begin bad++; $display("FAIL bounce_copy: got %h want %h", act_t, exp_t); end
    tick(60);
    total++; if (EditState !== 4'd0) begin bad++; $display("FAIL bounce_timeout: got %0d want 0", EditState); end
  endtask

  // Press Mode from an AMPM field and watch the whole strobe window.
  task automatic do_load(input bit alm);
    int hi = 0, other = 0, badbus = 0;
    logic [16:0] exp_b, act_b;
    exp_b = alm ? {4'(m_ah), 6'(m_am), 1'(m_aap), 6'd0} : {4'(m_th), 6'(m_tm), 1'(m_tap), 6'd0};
    mode_b = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (t == 10) mode_b = 1'b0;
      act_b = alm ? {AlarmHoursIn, AlarmMinsIn, Alarm_AM_PM_In, 6'd0}
                  : {SetHours, SetMins, Set_AM_PM, SetSecs};
      if (alm ? LoadAlm : LoadTime) begin
        hi++;
        if (act_b !== exp_b) badbus++;
      end
      if (alm ? LoadTime : LoadAlm) other++;
    end
    total++; if (hi != LH) begin bad++; $display("FAIL load%0d_width: got %0d want %0d", alm, hi, LH); end
    total++; if (badbus != 0) begin bad++; $display("FAIL load%0d_bus: got %0d bad cycles want 0", alm, badbus); end
    total++; if (other != 0) begin bad++; $display("FAIL load%0d_other_strobe: got %0d want 0", alm, other); end
    total++; if (EditState !== (alm ? 4'd0 : 4'd5)) begin
      bad++; $display("FAIL load%0d_next: got %0d want %0d", alm, EditState, alm ? 0 : 5); end
  endtask

  task automatic test_time_wrap();
    logic [16:0] exp_t, act_t;
    hc = 4'd11; mc = 6'd59; apc = 1'b1;
    press(1, 0, 0); m_th = 11; m_tm = 59; m_tap = 1;
    press(0, 1, 0); m_th = hr_inc(m_th);
    press(1, 0, 0);
    press(0, 1, 0); m_tm = (m_tm + 1) % 60;
    press(1, 0, 0);
    press(0, 1, 0); m_tap ^= 1;
    exp_t = {4'(m_th), 6'(m_tm), 1'(m_tap), 6'd0};
    act_t = {SetHours, SetMins, Set_AM_PM, SetSecs};
    total++; if (act_t !== {4'd12, 6'd0, 1'b0, 6'd0} || act_t !== exp_t) begin
      bad++; $display("FAIL time_wrap_shadow: got %h want %h", act_t, exp_t); end
    total++; if (EditState !== 4'd3) begin bad++; $display("FAIL time_wrap_state: got %0d want 3", EditState); end
    do_load(1'b0);
  endtask

  task automatic test_alarm_set();
    logic [10:0] exp_a, act_a;
    for (int i = 0; i < 6; i++) begin press(0, 1, 0); m_ah = hr_inc(m_ah); end
    total++; if (AlarmHoursIn !== 4'(m_ah) || AlarmHoursIn !== 4'd6) begin
      bad++; $display("FAIL alarm_hours: got %0d want %0d", AlarmHoursIn, m_ah); end
    press(1, 0, 0);
    for (int i = 0; i < 30; i++) begin press(0, 1, 0); m_am = (m_am + 1) % 60; end
    press(1, 0, 0);
    press(0, 1, 0); m_aap ^= 1;
    exp_a = {4'(m_ah), 6'(m_am), 1'(m_aap)};
    act_a = {AlarmHoursIn, AlarmMinsIn, Alarm_AM_PM_In};
    total++; if (act_a !== exp_a) begin bad++; $display("FAIL alarm_shadow: got %h want %h", act_a, exp_a); end
    do_load(1'b1);
  endtask

  task automatic test_edit_timeout();
    int strobes = 0;
    logic [3:0] st_mid;
    logic [16:0] exp_t, act_t;
    randomize_now();
    press(1, 0, 0); m_th = hc; m_tm = mc; m_tap = apc;
    press(1, 0, 0);
    total++; if (EditState !== 4'd2) begin bad++; $display("FAIL timeout_enter: got %0d want 2", EditState); end
    st_mid = 4'hf;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (LoadTime || LoadAlm) strobes++;
      if (i == 24) st_mid = EditState;
    end
    total++; if (st_mid !== 4'd2) begin bad++; $display("FAIL timeout_early: got %0d want 2", st_mid); end
    total++; if (EditState !== 4'd0) begin bad++; $display("FAIL timeout_run: got %0d want 0", EditState); end
    total++; if (strobes != 0) begin bad++; $display("FAIL timeout_strobe: got %0d want 0", strobes); end
    exp_t = {4'(m_th), 6'(m_tm), 1'(m_tap), 6'd0};
    act_t = {SetHours, SetMins, Set_AM_PM, SetSecs};
    total++; if (act_t !== exp_t) begin bad++; $display("FAIL timeout_shadow: got %h want %h", act_t, exp_t); end
  endtask

  task automatic test_random_edit();
    int nh, nm, na;
    logic [16:0] exp_t, act_t;
    for (int trial = 0; trial < 3; trial++) begin
      randomize_now();
      nh = $urandom_range(0, 13); nm = $urandom_range(0, 4); na = $urandom_range(0, 2);
      press(1, 0, 0); m_th = hc; m_tm = mc; m_tap = apc;
      for (int i = 0; i < nh; i++) begin press(0, 1, 0); m_th = hr_inc(m_th); end
      press(1, 0, 0);
      for (int i = 0; i < nm; i++) begin press(0, 1, 0); m_tm = (m_tm + 1) % 60; end
      press(1, 0, 0);
      for (int i = 0; i < na; i++) begin press(0, 1, 0); m_tap ^= 1; end
      tick(70);
      total++; if (EditState !== 4'd0) begin bad++; $display("FAIL rand%0d_state: got %0d want 0", trial, EditState); end
      exp_t = {4'(m_th), 6'(m_tm), 1'(m_tap), 6'd0};
      act_t = {SetHours, SetMins, Set_AM_PM, SetSecs};
      total++; if (act_t !== exp_t) begin bad++; $display("FAIL rand%0d_shadow: got %h want %h", trial, act_t, exp_t); end
    end
  endtask

  task automatic test_snooze();
    int phase = 0, lows = 0, highs = 0, late = 0;
    press(0, 1, 0); m_en ^= 1;
    total++; if (AlarmEnable !== 1'(m_en)) begin bad++; $display("FAIL snooze_enable: got %b want %0d", AlarmEnable, m_en); end
    alarm = 1'b1;
    tick(2);
    total++; if (Buzzer !== 1'b1) begin bad++; $display("FAIL buzzer_on: got %b want 1", Buzzer); end
    snz_b = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (t == 10) snz_b = 1'b0;
      case (phase)
        0: if (!Buzzer) begin phase = 1; lows = 1; end
        1: if (!Buzzer) lows++; else begin phase = 2; highs = 1; end
        2: if (Buzzer) highs++; else phase = 3;
        default: if (Buzzer) late++;
      endcase
    end
    total++; if (phase != 3) begin bad++; $display("FAIL snooze_sequence: got phase %0d want 3", phase); end
    total++; if (lows != SZ) begin bad++; $display("FAIL snooze_len: got %0d want %0d", lows, SZ); end
    total++; if (highs != AT) begin bad++; $display("FAIL silence_after: got %0d want %0d", highs, AT); end
    total++; if (late != 0) begin bad++; $display("FAIL silence_hold: got %0d want 0", late); end
    alarm = 1'b0;
    tick(3);
    total++; if (Buzzer !== 1'b0) begin bad++; $display("FAIL alarm_off: got %b want 0", Buzzer); end
    alarm = 1'b1;
    tick(3);
    total++; if (Buzzer !== 1'b1) begin bad++; $display("FAIL silence_cleared: got %b want 1", Buzzer); end
    press(0, 1, 0); m_en ^= 1;
    total++; if ({AlarmEnable, Buzzer} !== {1'(m_en), 1'b0}) begin
      bad++; $display("FAIL disarm: got %b want %b", {AlarmEnable, Buzzer}, {1'(m_en), 1'b0}); end
    alarm = 1'b0;
    tick(3);
  endtask

  task automatic test_simul_and_reset();
    bit seen = 0;
    randomize_now();
    press(1, 0, 0); m_th = hc; m_tm = mc; m_tap = apc;
    press(1, 1, 0);
    total++; if (EditState !== 4'd2) begin bad++; $display("FAIL simul_state: got %0d want 2", EditState); end
    total++; if (SetHours !== 4'(m_th)) begin bad++; $display("FAIL simul_hours: got %0d want %0d", SetHours, m_th); end
    press(1, 0, 0);
    mode_b = 1'b1;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (LoadTime) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL midload_start: got 0 want LoadTime 1 within 30 cycles"); end
    tick(3);
    rst = 1'b1; mode_b = 1'b0;
    #1;
    model_reset();
    total++; if ({LoadTime, LoadAlm} !== 2'b00) begin bad++; $display("FAIL midload_strobe: got %b want 00", {LoadTime, LoadAlm}); end
    total++; if (EditState !== 4'd0) begin bad++; $display("FAIL midload_state: got %0d want 0", EditState); end
    total++; if ({SetHours, SetMins, Set_AM_PM, AlarmHoursIn, AlarmMinsIn, Alarm_AM_PM_In} !==
                 {4'(m_th), 6'(m_tm), 1'(m_tap), 4'(m_ah), 6'(m_am), 1'(m_aap)}) begin
      bad++; $display("FAIL midload_shadows: got %h want %h",
        {SetHours, SetMins, Set_AM_PM, AlarmHoursIn, AlarmMinsIn, Alarm_AM_PM_In},
        {4'(m_th), 6'(m_tm), 1'(m_tap), 4'(m_ah), 6'(m_am), 1'(m_aap)}); end
    tick(3);
    rst = 1'b0;
    tick(5);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_time_wrap();
    test_alarm_set();
    test_edit_timeout();
    test_random_edit();
    test_snooze();
    test_simul_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
